// File: rtl/spi_reg_bank_if.sv
// SPI pad bundle between an external controller and spi_reg_bank.
// sclk/copi/ncs come from the controller asynchronously; cipo is returned by the peripheral.
interface spi_reg_bank_if;
   logic sclk;
   logic copi;
   logic ncs;
   logic cipo;

   modport master (output sclk, output copi, output ncs, input cipo);
   modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-frame register bank driving the PWM control registers.
// Optional CIPO read-back path is compiled in with `define SPI_READBACK_EN.
module spi_reg_bank #(
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_reg_bank_if.slave spi,
   output logic [7:0]    en_reg_out_7_0,
   output logic [7:0]    en_reg_out_15_8,
   output logic [7:0]    en_reg_pwm_7_0,
   output logic [7:0]    en_reg_pwm_15_8,
   output logic [7:0]    pwm_duty_cycle,
   output logic          wr_strobe
);
   logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
   logic                   sclk_prev_q, ncs_prev_q;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_rise, ncs_fall, ncs_rise, sample, commit;
   logic                   active_q, active_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [15:0]            rx_q, rx_d;
   logic [7:0]             regs_q [5];
   logic [7:0]             regs_d [5];
   logic                   wr_strobe_q, wr_strobe_d;

   // ncs resets low so a frame already running at reset release never shows a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
         copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s    = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ncs_fall  = ~ncs_s & ncs_prev_q;
   assign ncs_rise  = ncs_s & ~ncs_prev_q;
   assign sample    = sclk_rise & ~ncs_s & active_q;
   assign commit    = ncs_rise & active_q & (cnt_q == 5'd16) & rx_q[15] & (rx_q[14:8] <= 7'd4);

   always_comb begin
      active_d    = active_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      if (ncs_fall) begin
         active_d = 1'b1;
         cnt_d    = 5'd0;
         rx_d     = 16'h0000;
      end else if (ncs_rise) begin
         active_d = 1'b0;
         if (commit) begin
            for (int i = 0; i < 5; i++) begin
               if (rx_q[10:8] == 3'(i)) regs_d[i] = rx_q[7:0];
            end
            wr_strobe_d = 1'b1;
         end
      end else if (sample) begin
         rx_d = {rx_q[14:0], copi_s};
         // 17 is sticky: any frame longer than 16 bits can never commit.
         if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q    <= 1'b0;
         cnt_q       <= 5'd0;
         rx_q        <= 16'h0000;
         wr_strobe_q <= 1'b0;
         for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
      end else begin
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         wr_strobe_q <= wr_strobe_d;
         regs_q      <= regs_d;
      end
   end

`ifdef SPI_READBACK_EN
   logic       sclk_fall;
   logic [6:0] rd_addr;
   logic [7:0] rd_val;
   logic [7:0] tx_q, tx_d;

   assign sclk_fall = ~sclk_s & sclk_prev_q;

   // Load on the 8th sampled bit; shifting starts only after the first data bit has been
   // presented, so the controller sees bit7 on the rising edge that follows the address.
   always_comb begin
      rd_addr = {rx_q[5:0], copi_s};
      rd_val  = 8'h00;
      for (int i = 0; i < 5; i++) begin
         if (rd_addr == 7'(i)) rd_val = regs_q[i];
      end
      tx_d = tx_q;
      if (ncs_s) begin
         tx_d = 8'h00;
      end else if (sample && (cnt_q == 5'd7) && !rx_q[6]) begin
         tx_d = rd_val;
      end else if (sclk_fall && active_q && (cnt_q >= 5'd9)) begin
         tx_d = {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_q <= 8'h00;
      else        tx_q <= tx_d;
   end

   assign spi.cipo = tx_q[7] & ~ncs_s;
`else
   assign spi.cipo = 1'b0;
`endif

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];
   assign wr_strobe       = wr_strobe_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed vector table, mid-frame reset sequence and random
// frames checked against a frame-level model of the register bank.
module tb_spi_reg_bank;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_strobes;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;
  int         n_vec = 0;
  int         n_err = 0;
  int         strobe_cnt = 0;
  logic [7:0] model [5];
  vec_t       tbl [9];

  spi_reg_bank_if spi ();

  spi_reg_bank #(.SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic spi_bit(input logic b, output logic seen);
    spi.copi = b;
    step(HALF);
    seen = spi.cipo;
    spi.sclk = 1'b1;
    step(HALF);
    spi.sclk = 1'b0;
  endtask

  // One frame of nbits (MSB first), then checks strobe, latency, read data and registers.
  task automatic run_frame(input logic [31:0] bits, input int nbits, output int strobes);
    logic [7:0] hdr, rd, exp_rd;
    logic       seen;
    int         first_k, pre, exp_s;
    hdr    = 8'(bits >> (nbits - 8));
    exp_s  = (nbits == 16 && hdr[7] && hdr[6:0] <= 7'd4) ? 1 : 0;
    exp_rd = 8'h00;
`ifdef SPI_READBACK_EN
    if (nbits >= 16 && !hdr[7] && hdr[6:0] <= 7'd4) exp_rd = model[hdr[2:0]];
`endif
    pre     = strobe_cnt;
    rd      = 8'h00;
    first_k = -1;
    spi.ncs = 1'b0;
    step(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(bits[nbits-1-i], seen);
      if (i >= 8 && i < 16) rd = {rd[6:0], seen};
    end
    step(HALF);
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (wr_strobe === 1'b1 && first_k < 0) first_k = k;
    end
    strobes = strobe_cnt - pre;
    check("strobe_count", 40'(strobes), 40'(exp_s));
    if (exp_s == 1) check("write_latency", 40'(first_k), 40'(SYNC + 1));
    if (nbits >= 16) check("cipo_data", 40'(rd), 40'(exp_rd));
    check("cipo_idle", 40'(spi.cipo), 40'(0));
    if (exp_s == 1) model[hdr[2:0]] = bits[7:0];
    check("regs_vs_model", dut_regs(), model_regs());
  endtask

  initial begin
    int         strobes;
    int         pre;
    logic       seen;
    logic [15:0] f;
    logic [31:0] fb;
    int          nb;

    tbl[0] = '{32'h0000_84AA, 16, 40'hAA_00_00_00_00, 1};
    tbl[1] = '{32'h0000_8001, 16, 40'hAA_00_00_00_01, 1};
    tbl[2] = '{32'h0000_8102, 16, 40'hAA_00_00_02_01, 1};
    tbl[3] = '{32'h0000_8204, 16, 40'hAA_00_04_02_01, 1};
    tbl[4] = '{32'h0000_8308, 16, 40'hAA_08_04_02_01, 1};
    tbl[5] = '{32'h0000_082F, 12, 40'hAA_08_04_02_01, 0};
    tbl[6] = '{32'h0001_04EF, 17, 40'hAA_08_04_02_01, 0};
    tbl[7] = '{32'h0000_85FF, 16, 40'hAA_08_04_02_01, 0};
    tbl[8] = '{32'h0000_0400, 16, 40'hAA_08_04_02_01, 0};

    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    rst_n    = 1'b0;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    step(5);
    check("reset_regs", dut_regs(), 40'h0);
    check("reset_cipo", 40'(spi.cipo), 40'(0));
    check("reset_strobe", 40'(wr_strobe), 40'(0));
    rst_n = 1'b1;
    step(SYNC + 3);

    for (int v = 0; v < 9; v++) begin
      run_frame(tbl[v].bits, tbl[v].nbits, strobes);
      check("table_regs", dut_regs(), tbl[v].exp_regs);
      check("table_strobes", 40'(strobes), 40'(tbl[v].exp_strobes));
    end

    // Reset six bits into a write frame; the remainder of that frame must be ignored.
    pre     = strobe_cnt;
    f       = 16'h8255;
    spi.ncs = 1'b0;
    step(HALF);
    for (int i = 0; i < 6; i++) spi_bit(f[15-i], seen);
    rst_n = 1'b0;
    step(2);
    check("midframe_reset_regs", dut_regs(), 40'h0);
    check("midframe_reset_strobe", 40'(wr_strobe), 40'(0));
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    rst_n = 1'b1;
    step(1);
    for (int i = 6; i < 16; i++) spi_bit(f[15-i], seen);
    step(HALF);
    spi.ncs = 1'b1;
    step(8);
    check("orphan_frame_strobe", 40'(strobe_cnt - pre), 40'(0));
    check("orphan_frame_regs", dut_regs(), 40'h0);
    run_frame(32'h0000_8255, 16, strobes);
    check("post_reset_pwm_7_0", 40'(r2), 40'h55);

    run_frame(32'h0000_843C, 16, strobes);
    run_frame(32'h0000_0400, 16, strobes);
    run_frame(32'h0000_1000, 16, strobes);

    for (int n = 0; n < 24; n++) begin
      f[15]   = ($urandom_range(0, 3) != 0);
      f[14:8] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 7));
      f[7:0]  = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       begin nb = 12; fb = 32'(f >> 4); end
        1:       begin nb = 17; fb = {15'h0, f, 1'($urandom)}; end
        default: begin nb = 16; fb = {16'h0, f}; end
      endcase
      run_frame(fb, nb, strobes);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI-slave register bank that sits directly upstream of the PWM peripheral. It receives 16-bit write frames from an external SPI controller over asynchronous pad inputs, then synchronises and decodes them. It holds the five 8-bit control registers that drive the PWM peripheral: output enables, PWM enables and duty cycle. An optional read-back path returns register contents on a CIPO line.

## Interface
Parameters:
- SYNC_STAGES, 2, depth of the synchroniser flop chain on sclk/copi/ncs (legal: 2..4)

Ports:
- clk  input  1  system clock; every flop in the block is clocked by it
- rst_n  input  1  reset, asynchronous, active-low
- sclk  input  1  SPI clock from pad, asynchronous to clk
- copi  input  1  SPI controller-out data, asynchronous
- ncs  input  1  SPI chip select, active-low, asynchronous
- cipo  output  1  SPI peripheral-out data; 0 when ncs high or read-back not compiled in
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_strobe  output  1  one-clk pulse when a register write commits

## Operation
- SPI mode 0, MSB first. COPI is sampled on each synchronised sclk rising edge while synchronised ncs is low.
- Frame of 16 bits: bit15 = R/W (1 = write, 0 = read), bits14:8 = address, bits7:0 = data.
- All three inputs pass through SYNC_STAGES flops. One further flop each holds the previous value for edge detection.
- Bit counter (5 bits):
  - Cleared on the synchronised ncs falling edge.
  - Increments on each sampled bit.
  - Saturates at 17, which marks the frame as overlong.
- Commit happens on the synchronised ncs rising edge, and only if all of the following hold:
  - count == 16
  - R/W = 1
  - address <= 0x04
- On commit, the addressed register takes the data byte and wr_strobe pulses. Otherwise the frame is discarded silently and no register changes.
- Addresses 0x05..0x7F: writes are ignored; reads return 0x00.
- A new ncs falling edge abandons any partial frame with no side effects.
- Reset values: all five registers 0x00, wr_strobe 0, cipo 0, counter 0, shift register 0.

## Timing
- Write latency: SYNC_STAGES+1 rising clk edges after raw ncs rises. The register value and wr_strobe become visible together after that edge (3 edges with the default).
- wr_strobe is high for exactly one clk cycle per committed frame.
- Requirements on sclk:
  - Each sclk phase must be at least SYNC_STAGES+2 clk cycles.
  - ncs must be high for at least SYNC_STAGES+2 clk cycles between frames.
  - Shorter pulses are unsupported and their behaviour is undefined.
- Reset asserted mid-frame clears everything immediately. After rst_n releases, a frame already in progress is not recognised; the next ncs falling edge starts cleanly.
- A register commit and a read of the same address never overlap, because ncs serialises frames.

## Configuration
- SPI_READBACK_EN defined:
  - On a read frame, the addressed register value (or 0x00 for an invalid address) is loaded into the output shift register on the same clk edge that samples bit 8, the last address bit.
  - cipo presents bit7 of that value from that edge.
  - The shift register shifts on each subsequent synchronised sclk falling edge, so each data bit is stable before the controller's next rising edge.
  - cipo returns to 0 when ncs is synchronised high.
- SPI_READBACK_EN undefined: no shift register exists, cipo is tied 0, and read frames are decoded but have no effect.

## Test plan
- Reset: hold rst_n low for 5 clk -> all registers 0x00, cipo 0, wr_strobe 0.
- Write 0x84 0xAA (addr 0x04 = 0xAA), sclk = clk/10 -> pwm_duty_cycle = 0xAA exactly 3 clk edges after ncs rises; single wr_strobe pulse; other registers unchanged.
- Write addr 0x00..0x03 with 0x01, 0x02, 0x04, 0x08 back-to-back -> each register holds its value and wr_strobe pulses 4 times.
- Abort and overlong:
  - 12-bit frame, then ncs high -> no change, no wr_strobe.
  - 17-bit frame targeting 0x02 -> no change.
  - Write 0x85 0xFF (invalid address) -> no register changes.
- Reset mid-frame: pulse rst_n low after 6 bits, then send a full write 0x82 0x55 -> en_reg_pwm_7_0 = 0x55.
- With SPI_READBACK_EN, after writing 0x04 = 0x3C, send read frame 0x04 0x00 -> cipo yields 0x3C MSB-first over the 8 data sclk cycles; a read of 0x10 yields 0x00.
